ttc_cfg_arbiter_lite3: RTL and testbench
========================================

Name: ttc_cfg_arbiter_lite3

Overview:
- Shares the single write/select interface of one timer-counter-lite channel between NUM_REQ configuration requesters, e.g. the APB host, the power-management controller and a reload scheduler.
- Arbitrates round-robin, latches the winning address and data, and drives one write-select strobe plus pwdata3 for exactly one cycle.
- Returns a one-cycle acknowledge to the winner.
- Sits between the requesters and the timer-counter-lite select inputs.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 16, write data width; matches the timer-counter pwdata3 width.

Ports:
- pclk3  input  1  system clock; all logic rising-edge.
- p_reset3  input  1  reset, synchronous, active-high.
- req3  input  NUM_REQ  per-requester write request; level, held until ack.
- req_addr3  input  3*NUM_REQ  per-requester register index, packed, requester i at [3i+2:3i].
- req_data3  input  DATA_W*NUM_REQ  per-requester write data, packed.
- ack3  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- busy3  output  1  high while in WRITE or DONE.
- pwdata3  output  DATA_W  latched write data to the timer counter.
- clk_ctrl_reg_sel3, cntr_ctrl_reg_sel3, interval_reg_sel3, match_1_reg_sel3, match_2_reg_sel3, match_3_reg_sel3, intr_en_reg_sel3  output  1 each  one-hot write selects.
- clear_interrupt3  output  1  interrupt clear strobe.

Behaviour:
- Register index decode:
  - 0 clk_ctrl, 1 cntr_ctrl, 2 interval, 3 match_1, 4 match_2, 5 match_3, 6 intr_en, 7 clear_interrupt.
  - Index 7 drives clear_interrupt3; the data is don't-care but still driven.
- FSM states IDLE, WRITE, DONE; 2 bits; reset state IDLE.
- IDLE:
  - If any req3 bit is high, pick the winner round-robin starting at rr_ptr.
  - Latch winner index, req_addr3 and req_data3 into registers, then go to WRITE.
  - Otherwise stay in IDLE.
- WRITE:
  - Exactly one select (or clear_interrupt3) is high, decoded from the latched address.
  - pwdata3 holds the latched data. Go to DONE.
- DONE:
  - ack3[winner] is high for this cycle only.
  - rr_ptr becomes winner+1, modulo NUM_REQ. Go to IDLE.
- Latency: req3 high in IDLE at cycle k gives the select in cycle k+1 and ack3 in cycle k+2.
  - Minimum spacing between back-to-back grants is 3 cycles.
- Handshake:
  - Requester keeps req3, req_addr3 and req_data3 stable until it sees ack3, then drops req3 the next cycle.
  - Data is latched at grant, so changes after grant are ignored.
  - req3 changes outside IDLE have no effect.
- Outputs are registered.
  - All selects and clear_interrupt3 are 0 outside WRITE.
  - pwdata3 holds its last value outside WRITE (0 after reset).
- Fairness: with all requesters continuously requesting, each is granted once per NUM_REQ grants. Worst-case wait is NUM_REQ*3 cycles.
- Simultaneous requests: the lowest index at or above rr_ptr wins, wrapping.
- A requester that does not drop req3 after ack3 is re-arbitrated as a new request (no lockout).
- Reset values:
  - state IDLE, rr_ptr 0, all ack3 0, busy3 0, all selects 0, clear_interrupt3 0, pwdata3 0.
- Reset mid-operation:
  - An in-flight write is abandoned.
  - If reset is asserted in the WRITE cycle, the select is deasserted from the next cycle.
  - No ack3 is issued; the requester must re-request.

Optional Feature:
- Macro TTC_CFG_PRIO_EN.
- Defined: requester 0 has fixed absolute priority. If req3[0] is high in IDLE, it wins regardless of rr_ptr, and rr_ptr is not updated on its grants. Requesters 1..NUM_REQ-1 stay round-robin among themselves.
- Undefined: pure round-robin over all requesters as above.

Decomposition:
- Shared package ttc_cfg_pkg3 holds:
  - register index localparams (TTC_IDX_CLK_CTRL .. TTC_IDX_CLR_INT);
  - FSM state encoding (ST_IDLE, ST_WRITE, ST_DONE).
- One sub-module, ttc_rr_pick3:
  - combinational round-robin picker;
  - inputs: request vector and pointer; outputs: one-hot grant and winner index;
  - reused by other schedulers.

Test Plan:
- Single request: req3=3'b010, addr 2, data 16'h1234 -> interval_reg_sel3 high cycle k+1 with pwdata3=16'h1234; ack3=3'b010 at k+2; busy3 high k+1..k+2.
- All three requesting continuously, distinct addr/data -> grant order 0,1,2,0 with selects 3 cycles apart; each ack matches the requester's data.
- Address 7 from requester 2 -> clear_interrupt3 pulses 1 cycle; no *_sel3 asserted.
- req_data3 changed after grant -> pwdata3 keeps the originally latched value.
- p_reset3 asserted in WRITE cycle -> select low the next cycle, no ack3, rr_ptr=0; re-request is served normally.
- TTC_CFG_PRIO_EN defined, req3[0] reasserted continuously with req3[2] pending -> requester 0 always wins. Undefined -> requester 2 is served within 2 grants.

Source files
------------

// File: rtl/ttc_cfg_arbiter_lite3_pkg.sv
// ============================================================================
// Module   : ttc_cfg_pkg3
// Brief    : Shared register-index constants, FSM encoding and select decode
//            for the timer-counter-lite configuration arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ttc_cfg_pkg3;

    localparam logic [2:0] TTC_IDX_CLK_CTRL  = 3'd0;
    localparam logic [2:0] TTC_IDX_CNTR_CTRL = 3'd1;
    localparam logic [2:0] TTC_IDX_INTERVAL  = 3'd2;
    localparam logic [2:0] TTC_IDX_MATCH_1   = 3'd3;
    localparam logic [2:0] TTC_IDX_MATCH_2   = 3'd4;
    localparam logic [2:0] TTC_IDX_MATCH_3   = 3'd5;
    localparam logic [2:0] TTC_IDX_INTR_EN   = 3'd6;
    localparam logic [2:0] TTC_IDX_CLR_INT   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } ttc_state_t;

    // One strobe per register index; bit 7 is the interrupt clear.
    function automatic logic [7:0] ttc_decode_sel(input logic [2:0] idx);
        ttc_decode_sel = 8'b0000_0001 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ttc_cfg_arbiter_lite3_if.sv
// ============================================================================
// Module   : ttc_cfg_arbiter_lite3_if
// Brief    : Requester bundle and timer-counter write/select bus of the
//            configuration arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ttc_cfg_arbiter_lite3_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req3;
    logic [3*NUM_REQ-1:0]      req_addr3;
    logic [DATA_W*NUM_REQ-1:0] req_data3;
    logic [NUM_REQ-1:0]        ack3;
    logic                      busy3;
    logic [DATA_W-1:0]         pwdata3;
    logic                      clk_ctrl_reg_sel3;
    logic                      cntr_ctrl_reg_sel3;
    logic                      interval_reg_sel3;
    logic                      match_1_reg_sel3;
    logic                      match_2_reg_sel3;
    logic                      match_3_reg_sel3;
    logic                      intr_en_reg_sel3;
    logic                      clear_interrupt3;

    modport master (
        output req3, req_addr3, req_data3,
        input  ack3, busy3, pwdata3,
        input  clk_ctrl_reg_sel3, cntr_ctrl_reg_sel3, interval_reg_sel3,
        input  match_1_reg_sel3, match_2_reg_sel3, match_3_reg_sel3,
        input  intr_en_reg_sel3, clear_interrupt3
    );

    modport slave (
        input  req3, req_addr3, req_data3,
        output ack3, busy3, pwdata3,
        output clk_ctrl_reg_sel3, cntr_ctrl_reg_sel3, interval_reg_sel3,
        output match_1_reg_sel3, match_2_reg_sel3, match_3_reg_sel3,
        output intr_en_reg_sel3, clear_interrupt3
    );
endinterface

`default_nettype wire

// File: rtl/ttc_rr_pick3.sv
// ============================================================================
// Module   : ttc_rr_pick3
// Brief    : Combinational round-robin picker: lowest requesting index at or
//            above the pointer wins, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttc_rr_pick3 #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [PTR_W-1:0]   i_ptr,
    output logic      [NUM_REQ-1:0] o_grant,
    output logic      [PTR_W-1:0]   o_idx
);

    localparam logic [PTR_W:0] c_NUM = NUM_REQ[PTR_W:0];

    logic [2*NUM_REQ-1:0] w_shift;
    logic [NUM_REQ-1:0]   w_rot;
    logic [PTR_W-1:0]     w_off;
    logic [PTR_W:0]       w_sum;

    // Rotating a doubled copy puts the pointer's requester at bit 0.
    assign w_shift = {i_req, i_req} >> i_ptr;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_rot
        assign w_rot[k] = w_shift[k];
    end

    always_comb begin
        o_grant = '0;
        w_off   = '0;
        w_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = PTR_W'(k);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= c_NUM) begin
            w_sum = w_sum - c_NUM;
        end
        o_idx = w_sum[PTR_W-1:0];
        if (|i_req) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ttc_cfg_arbiter_lite3.sv
// ============================================================================
// Module   : ttc_cfg_arbiter_lite3
// Brief    : Round-robin arbiter sharing one timer-counter-lite write/select
//            port between NUM_REQ configuration requesters.
//            Optional macro TTC_CFG_PRIO_EN: requester 0 gets fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttc_cfg_arbiter_lite3
    import ttc_cfg_pkg3::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16
) (
    input wire logic               pclk3,
    input wire logic               p_reset3,
    ttc_cfg_arbiter_lite3_if.slave bus
);

    localparam int                 c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] c_ONE   = NUM_REQ'(1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] w_req_rr;
    logic [NUM_REQ-1:0] w_pick_grant;
    logic [c_PTR_W-1:0] w_pick_idx;
    logic [c_PTR_W-1:0] w_win;
    logic               w_prio0;
    logic               w_any;
    logic [2:0]         w_addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  w_data_arr [NUM_REQ];

    ttc_state_t         r_state;
    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [c_PTR_W-1:0] r_winner;
    logic               r_prio_grant;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_busy;
    logic [7:0]         r_sel;
    logic [DATA_W-1:0]  r_pwdata;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_addr_arr[i] = bus.req_addr3[3*i +: 3];
        assign w_data_arr[i] = bus.req_data3[DATA_W*i +: DATA_W];
    end

`ifdef TTC_CFG_PRIO_EN
    // Requester 0 bypasses the rotation; the rest share it.
    assign w_req_rr = {bus.req3[NUM_REQ-1:1], 1'b0};
    assign w_prio0  = bus.req3[0];
`else
    assign w_req_rr = bus.req3;
    assign w_prio0  = 1'b0;
`endif

    ttc_rr_pick3 #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_pick (
        .i_req   (w_req_rr),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    assign w_any = w_prio0 | (|w_pick_grant);
    assign w_win = w_prio0 ? '0 : w_pick_idx;

    always_ff @(posedge pclk3) begin
        if (p_reset3) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_winner     <= '0;
            r_prio_grant <= 1'b0;
            r_ack        <= '0;
            r_busy       <= 1'b0;
            r_sel        <= '0;
            r_pwdata     <= '0;
        end else begin
            r_ack <= '0;
            r_sel <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        // Address and data are captured here; later changes are ignored.
                        r_winner     <= w_win;
                        r_prio_grant <= w_prio0;
                        r_sel        <= ttc_decode_sel(w_addr_arr[w_win]);
                        r_pwdata     <= w_data_arr[w_win];
                        r_busy       <= 1'b1;
                        r_state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_ack   <= c_ONE << r_winner;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!r_prio_grant) begin
                        r_rr_ptr <= (r_winner == c_LAST) ? '0 : r_winner + 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack3               = r_ack;
    assign bus.busy3              = r_busy;
    assign bus.pwdata3            = r_pwdata;
    assign bus.clk_ctrl_reg_sel3  = r_sel[TTC_IDX_CLK_CTRL];
    assign bus.cntr_ctrl_reg_sel3 = r_sel[TTC_IDX_CNTR_CTRL];
    assign bus.interval_reg_sel3  = r_sel[TTC_IDX_INTERVAL];
    assign bus.match_1_reg_sel3   = r_sel[TTC_IDX_MATCH_1];
    assign bus.match_2_reg_sel3   = r_sel[TTC_IDX_MATCH_2];
    assign bus.match_3_reg_sel3   = r_sel[TTC_IDX_MATCH_3];
    assign bus.intr_en_reg_sel3   = r_sel[TTC_IDX_INTR_EN];
    assign bus.clear_interrupt3   = r_sel[TTC_IDX_CLR_INT];

endmodule

`default_nettype wire

// File: tb/tb_ttc_cfg_arbiter_lite3.sv
// ============================================================================
// Module   : tb_ttc_cfg_arbiter_lite3
// Brief    : Self-checking bench for ttc_cfg_arbiter_lite3 against a
//            transaction-level arbitration model (honours TTC_CFG_PRIO_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ttc_cfg_arbiter_lite3;

    localparam int N  = 3;
    localparam int DW = 16;
`ifdef TTC_CFG_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic pclk3    = 1'b0;
    logic p_reset3 = 1'b1;

    ttc_cfg_arbiter_lite3_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    ttc_cfg_arbiter_lite3 #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .pclk3    (pclk3),
        .p_reset3 (p_reset3),
        .bus      (bus)
    );

    always #5 pclk3 = ~pclk3;

    int            checks = 0;
    int            errors = 0;
    int            m_ptr  = 0;
    logic [N-1:0]  req_v;
    logic [2:0]    a [N];
    logic [DW-1:0] d [N];
    logic [7:0]    sel_v;

    assign sel_v = {bus.clear_interrupt3, bus.intr_en_reg_sel3, bus.match_3_reg_sel3,
                    bus.match_2_reg_sel3, bus.match_1_reg_sel3, bus.interval_reg_sel3,
                    bus.cntr_ctrl_reg_sel3, bus.clk_ctrl_reg_sel3};

    task automatic tick();
        @(posedge pclk3);
        #1;
    endtask

    task automatic drive();
        bus.req3 = req_v;
        for (int i = 0; i < N; i++) begin
            bus.req_addr3[3*i +: 3]   = a[i];
            bus.req_data3[DW*i +: DW] = d[i];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lowest requesting index at or after the pointer, wrapping; optional
    // absolute priority for requester 0.
    function automatic int model_pick(input logic [N-1:0] r, input int ptr);
        if (PRIO && r[0]) return 0;
        for (int off = 0; off < N; off++) begin
            int i;
            i = (ptr + off) % N;
            if (!(PRIO && i == 0) && r[i]) return i;
        end
        return -1;
    endfunction

    // Walks one grant from an IDLE cycle with requests already driven.
    task automatic do_grant(input bit sticky, input bit chg);
        int            w;
        logic [DW-1:0] edata;
        logic [7:0]    esel;
        w = model_pick(req_v, m_ptr);
        if (w < 0) begin
            tick();
            return;
        end
        esel  = 8'd1 << a[w];
        edata = d[w];
        tick();
        chk("sel_write", sel_v, esel);
        chk("pwdata_write", bus.pwdata3, edata);
        chk("busy_write", bus.busy3, 1);
        chk("ack_write", bus.ack3, 0);
        if (chg) begin
            d[w] = ~d[w];
            drive();
        end
        tick();
        chk("ack_done", bus.ack3, 1 << w);
        chk("sel_done", sel_v, 0);
        chk("pwdata_hold", bus.pwdata3, edata);
        chk("busy_done", bus.busy3, 1);
        if (!(PRIO && w == 0)) m_ptr = (w + 1) % N;
        if (!sticky) begin
            req_v[w] = 1'b0;
            drive();
        end
        tick();
        chk("ack_idle", bus.ack3, 0);
        chk("busy_idle", bus.busy3, 0);
    endtask

    initial begin
        req_v = '0;
        for (int i = 0; i < N; i++) begin
            a[i] = 3'(i);
            d[i] = DW'(16'h1000 + i);
        end
        drive();
        p_reset3 = 1'b1;
        repeat (3) tick();
        chk("rst_ack", bus.ack3, 0);
        chk("rst_busy", bus.busy3, 0);
        chk("rst_sel", sel_v, 0);
        chk("rst_pwdata", bus.pwdata3, 0);
        p_reset3 = 1'b0;
        tick();

        // All three requesting continuously: grants 0,1,2,0.
        a[0] = 3'd0; d[0] = 16'hA000;
        a[1] = 3'd3; d[1] = 16'hB111;
        a[2] = 3'd6; d[2] = 16'hC222;
        req_v = 3'b111;
        drive();
        for (int g = 0; g < 4; g++) do_grant(1'b1, 1'b0);
        req_v = '0;
        drive();
        tick();

        // Single request to the interval register.
        a[1] = 3'd2; d[1] = 16'h1234; req_v = 3'b010;
        drive();
        do_grant(1'b0, 1'b0);

        // Interrupt clear from requester 2.
        a[2] = 3'd7; d[2] = 16'h5A5A; req_v = 3'b100;
        drive();
        do_grant(1'b0, 1'b0);

        // Data changed after grant must not reach pwdata3.
        a[0] = 3'd4; d[0] = 16'h0F0F; req_v = 3'b001;
        drive();
        do_grant(1'b0, 1'b1);

        // Reset during WRITE abandons the write and clears the pointer.
        a[1] = 3'd5; d[1] = 16'h7777; req_v = 3'b010;
        drive();
        tick();
        chk("rstw_sel", sel_v, 8'h20);
        p_reset3 = 1'b1;
        tick();
        chk("rstw_sel_off", sel_v, 0);
        chk("rstw_ack", bus.ack3, 0);
        chk("rstw_busy", bus.busy3, 0);
        p_reset3 = 1'b0;
        m_ptr = 0;
        a[0] = 3'd1; d[0] = 16'h2468;
        a[2] = 3'd0; d[2] = 16'h1357;
        req_v = 3'b111;
        drive();
        for (int g = 0; g < N; g++) do_grant(1'b0, 1'b0);

        // Requester 0 re-requesting continuously with requester 2 pending.
        a[0] = 3'd1; d[0] = 16'h00AA;
        a[2] = 3'd2; d[2] = 16'h00CC;
        req_v = 3'b101;
        drive();
        for (int g = 0; g < 2; g++) begin
            int w;
            w = model_pick(req_v, m_ptr);
            do_grant(w == 0, 1'b0);
        end
        req_v = '0;
        drive();
        tick();

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] && $urandom_range(0, 2) == 0) begin
                    req_v[i] = 1'b1;
                    a[i]     = 3'($urandom_range(0, 7));
                    d[i]     = DW'($urandom);
                end
            end
            drive();
            if (req_v != '0) begin
                do_grant($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            end else begin
                tick();
                chk("idle_sel", sel_v, 0);
                chk("idle_busy", bus.busy3, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
